// File: rtl/mem_arbiter.sv
// Two-master arbiter that shares one synchronous memory port between the 6502 core and a DMA/loader master.
// Optional build macro ARB_STATS_EN adds a saturating stall_count output.
module mem_arbiter #(
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned MIN_CPU_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rd_data,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wr_data,
  input  logic        dma_we,
  output logic        dma_gnt,
  output logic [7:0]  dma_rd_data,
  output logic        dma_rd_valid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  output logic        mem_we,
  input  logic [7:0]  mem_rd_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned HW = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(MIN_CPU_CYCLES);

  typedef enum logic [1:0] {
    ST_CPU    = 2'd0,
    ST_DMA    = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] burst, burst_nxt;
  logic [HW-1:0] hold, hold_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_CPU;
      burst        <= '0;
      hold         <= '0;
      dma_rd_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      burst        <= burst_nxt;
      hold         <= hold_nxt;
      dma_rd_valid <= (state == ST_DMA) && dma_req && !dma_we;
    end
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst;
    hold_nxt  = hold;
    case (state)
      ST_CPU: begin
        // A CPU write cycle is never stolen; hold-off must have run down to its last cycle.
        if (dma_req && !cpu_we && (hold <= HW'(1)))
          state_nxt = ST_DMA;
        else if (hold != '0)
          hold_nxt = hold - HW'(1);
      end
      ST_DMA: begin
        if (dma_req)
          burst_nxt = burst + BW'(1);
        if (!dma_req || (burst == BURST_LAST))
          state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        state_nxt = ST_CPU;
        hold_nxt  = HOLD_INIT;
        burst_nxt = '0;
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  assign cpu_rdy     = (state == ST_CPU);
  assign dma_gnt     = (state == ST_DMA);
  assign cpu_rd_data = mem_rd_data;
  assign dma_rd_data = mem_rd_data;

  always_comb begin
    mem_addr    = cpu_addr;
    mem_wr_data = cpu_wr_data;
    mem_we      = (state == ST_CPU) && cpu_we;
    if (state == ST_DMA) begin
      mem_addr    = dma_addr;
      mem_wr_data = dma_wr_data;
      mem_we      = dma_we && dma_req;
    end
    // Reset gates the write strobe combinationally so an in-flight DMA write is dropped at once.
    if (!resetn)
      mem_we = 1'b0;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_count <= '0;
    else if (!cpu_rdy && (stall_count != '1))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default, capped-burst and single-access instances with a memory model
// and scoreboard queues for DMA read data and memory writes.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_we;
  logic        dma_req_a, dma_req_b, dma_req_c, dma_req_d;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wr_data;
  logic        dma_we;

  logic        cpu_rdy_a, dma_gnt_a, dma_rd_valid_a, mem_we_a;
  logic [7:0]  cpu_rd_data_a, dma_rd_data_a, mem_wr_data_a, mem_rd_a;
  logic [15:0] mem_addr_a;
  logic        cpu_rdy_b, dma_gnt_b, dma_rd_valid_b, mem_we_b;
  logic [7:0]  cpu_rd_data_b, dma_rd_data_b, mem_wr_data_b, mem_rd_b;
  logic [15:0] mem_addr_b;
  logic        cpu_rdy_c, dma_gnt_c, dma_rd_valid_c, mem_we_c;
  logic [7:0]  cpu_rd_data_c, dma_rd_data_c, mem_wr_data_c, mem_rd_c;
  logic [15:0] mem_addr_c;
`ifdef ARB_STATS_EN
  logic [15:0] stall_a, stall_b, stall_c, stall_d;
  logic        cpu_rdy_d, dma_gnt_d, dma_rd_valid_d, mem_we_d;
  logic [7:0]  cpu_rd_data_d, dma_rd_data_d, mem_wr_data_d, mem_rd_d;
  logic [15:0] mem_addr_d;
`endif

  mem_arbiter u_a (
    .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy_a), .cpu_rd_data(cpu_rd_data_a), .dma_req(dma_req_a), .dma_addr(dma_addr),
    .dma_wr_data(dma_wr_data), .dma_we(dma_we), .dma_gnt(dma_gnt_a), .dma_rd_data(dma_rd_data_a),
    .dma_rd_valid(dma_rd_valid_a), .mem_addr(mem_addr_a), .mem_wr_data(mem_wr_data_a),
    .mem_we(mem_we_a), .mem_rd_data(mem_rd_a)
`ifdef ARB_STATS_EN
    , .stall_count(stall_a)
`endif
  );

  mem_arbiter #(.MAX_BURST(4), .MIN_CPU_CYCLES(4)) u_b (
    .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy_b), .cpu_rd_data(cpu_rd_data_b), .dma_req(dma_req_b), .dma_addr(dma_addr),
    .dma_wr_data(dma_wr_data), .dma_we(dma_we), .dma_gnt(dma_gnt_b), .dma_rd_data(dma_rd_data_b),
    .dma_rd_valid(dma_rd_valid_b), .mem_addr(mem_addr_b), .mem_wr_data(mem_wr_data_b),
    .mem_we(mem_we_b), .mem_rd_data(mem_rd_b)
`ifdef ARB_STATS_EN
    , .stall_count(stall_b)
`endif
  );

  mem_arbiter #(.MAX_BURST(1), .MIN_CPU_CYCLES(0)) u_c (
    .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy_c), .cpu_rd_data(cpu_rd_data_c), .dma_req(dma_req_c), .dma_addr(dma_addr),
    .dma_wr_data(dma_wr_data), .dma_we(dma_we), .dma_gnt(dma_gnt_c), .dma_rd_data(dma_rd_data_c),
    .dma_rd_valid(dma_rd_valid_c), .mem_addr(mem_addr_c), .mem_wr_data(mem_wr_data_c),
    .mem_we(mem_we_c), .mem_rd_data(mem_rd_c)
`ifdef ARB_STATS_EN
    , .stall_count(stall_c)
`endif
  );

`ifdef ARB_STATS_EN
  mem_arbiter #(.MAX_BURST(1024), .MIN_CPU_CYCLES(0)) u_d (
    .clk(clk), .resetn(resetn), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy_d), .cpu_rd_data(cpu_rd_data_d), .dma_req(dma_req_d), .dma_addr(dma_addr),
    .dma_wr_data(dma_wr_data), .dma_we(dma_we), .dma_gnt(dma_gnt_d), .dma_rd_data(dma_rd_data_d),
    .dma_rd_valid(dma_rd_valid_d), .mem_addr(mem_addr_d), .mem_wr_data(mem_wr_data_d),
    .mem_we(mem_we_d), .mem_rd_data(mem_rd_d), .stall_count(stall_d)
  );
  always @(posedge clk) mem_rd_d <= mem_addr_d[7:0];
`endif

  // Instance A gets a real 64 KiB memory; the others only need a registered address echo.
  logic [7:0] mem_a [0:65535];
  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a] <= mem_wr_data_a;
    mem_rd_a <= mem_a[mem_addr_a];
  end
  always @(posedge clk) mem_rd_b <= mem_addr_b[7:0];
  always @(posedge clk) mem_rd_c <= mem_addr_c[7:0];

  int checks = 0;
  int errors = 0;
  logic [7:0]  rd_q [$];
  logic [23:0] wr_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0]  er;
    logic [23:0] ew;
    if (dma_rd_valid_a) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=%0h expected=none", dma_rd_data_a);
      end else begin
        er = rd_q.pop_front();
        chk("dma_rd_data", {24'd0, dma_rd_data_a}, {24'd0, er});
      end
    end
    if (mem_we_a) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected actual=%0h expected=none", {mem_addr_a, mem_wr_data_a});
      end else begin
        ew = wr_q.pop_front();
        chk("mem_write", {8'd0, mem_addr_a, mem_wr_data_a}, {8'd0, ew});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int low;
    logic eg, er;
    resetn = 1'b0; cpu_addr = 16'h1234; cpu_wr_data = 8'h99; cpu_we = 1'b1;
    dma_req_a = 1'b1; dma_req_b = 1'b1; dma_req_c = 1'b1; dma_req_d = 1'b0;
    dma_addr = 16'h0300; dma_wr_data = 8'hCC; dma_we = 1'b1;
    mem_a[16'h0200] = 8'hA0; mem_a[16'h0201] = 8'hA1; mem_a[16'h0202] = 8'hA2;
    mem_a[16'h1234] = 8'h5A; mem_a[16'h0300] = 8'h3C;

    // Reset with both masters asserting
    repeat (2) tick();
    #2;
    chk("rst_cpu_rdy", cpu_rdy_a, 1);
    chk("rst_dma_gnt", dma_gnt_a, 0);
    chk("rst_mem_we", mem_we_a, 0);
    chk("rst_rd_valid", dma_rd_valid_a, 0);
    chk("rst_mem_addr", mem_addr_a, 16'h1234);
    chk("rst_mem_wr_data", mem_wr_data_a, 8'h99);
    chk("rst_gnt_b", dma_gnt_b, 0);
    tick();
    resetn = 1'b1; cpu_we = 1'b0; dma_req_a = 1'b0; dma_req_b = 1'b0; dma_req_c = 1'b0; dma_we = 1'b0;
    repeat (3) tick();

    // Read burst of three on A (and B, which stays below its cap)
    tick();
    dma_req_a = 1'b1; dma_req_b = 1'b1; dma_addr = 16'h0200;
    #2;
    chk("s2_req_rdy", cpu_rdy_a, 1);
    chk("s2_req_gnt", dma_gnt_a, 0);
    low = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      dma_addr = 16'h01FF + 16'(k);
      #2;
      chk("s2_gnt", dma_gnt_a, 1);
      chk("s2_rdy", cpu_rdy_a, 0);
      chk("s2_mem_addr", mem_addr_a, dma_addr);
      rd_q.push_back(8'h9F + 8'(k));
      low += cpu_rdy_a ? 0 : 1;
    end
    tick();
    dma_req_a = 1'b0; dma_req_b = 1'b0;
    #2;
    chk("s2_idle_gnt", dma_gnt_a, 1);
    chk("s2_idle_we", mem_we_a, 0);
    low += cpu_rdy_a ? 0 : 1;
    tick();
    cpu_we = 1'b1; cpu_wr_data = 8'h55;
    #2;
    chk("s2_refill_rdy", cpu_rdy_a, 0);
    chk("s2_refill_gnt", dma_gnt_a, 0);
    chk("s2_refill_addr", mem_addr_a, 16'h1234);
    chk("s2_refill_we", mem_we_a, 0);
    low += cpu_rdy_a ? 0 : 1;
    tick();
    cpu_we = 1'b0;
    #2;
    chk("s2_back_rdy", cpu_rdy_a, 1);
    chk("s2_cpu_rd_data", cpu_rd_data_a, 8'h5A);
    low += cpu_rdy_a ? 0 : 1;
    repeat (2) begin
      tick(); #2;
      low += cpu_rdy_a ? 0 : 1;
    end
    chk("s2_stall_cycles", low, 5);
    chk("s2_rd_drained", rd_q.size(), 0);
    repeat (6) tick();

    // Burst cap on B: 4 accesses, refill, 4 CPU cycles, repeating
    for (int i = 0; i < 30; i++) begin
      tick();
      dma_req_b = (i < 27);
      #2;
      eg = (i >= 1) && (i <= 27) && (((i - 1) % 9) < 4);
      er = !((i >= 1) && (i <= 27) && (((i - 1) % 9) < 5));
      chk($sformatf("s3_gnt_%0d", i), dma_gnt_b, eg);
      chk($sformatf("s3_rdy_%0d", i), cpu_rdy_b, er);
    end
`ifdef ARB_STATS_EN
    chk("s6_stall_count", stall_b, 20);
`endif

    // MAX_BURST=1, no hold-off on C
    for (int i = 0; i < 11; i++) begin
      tick();
      dma_req_c = (i < 9);
      #2;
      eg = (i >= 1) && (i <= 9) && (((i - 1) % 3) == 0);
      er = !((i >= 1) && (i <= 9) && (((i - 1) % 3) < 2));
      chk($sformatf("mb1_gnt_%0d", i), dma_gnt_c, eg);
      chk($sformatf("mb1_rdy_%0d", i), cpu_rdy_c, er);
      chk($sformatf("mb1_rdv_%0d", i), dma_rd_valid_c, (i == 2) || (i == 5) || (i == 8));
    end

    // Write protect on A: CPU writes are not stolen
    repeat (5) tick();
    for (int j = 0; j < 3; j++) begin
      tick();
      cpu_we = 1'b1; cpu_addr = 16'h0400 + 16'(j); cpu_wr_data = 8'h11 * 8'(j + 1); dma_req_a = 1'b1;
      #2;
      chk("s4_gnt", dma_gnt_a, 0);
      chk("s4_rdy", cpu_rdy_a, 1);
      chk("s4_we", mem_we_a, 1);
      wr_q.push_back({cpu_addr, cpu_wr_data});
    end
    tick();
    cpu_we = 1'b0; cpu_addr = 16'h1234;
    #2;
    chk("s4_gnt_pending", dma_gnt_a, 0);
    tick();
    dma_we = 1'b1; dma_addr = 16'h0500; dma_wr_data = 8'h77;
    #2;
    chk("s4_gnt_rise", dma_gnt_a, 1);
    chk("s4_dma_we", mem_we_a, 1);
    chk("s4_dma_addr", mem_addr_a, 16'h0500);
    wr_q.push_back({16'h0500, 8'h77});
    tick();
    dma_req_a = 1'b0; dma_we = 1'b0;
    #2;
    chk("s4_idle_gnt", dma_gnt_a, 1);
    chk("s4_idle_we", mem_we_a, 0);
    repeat (2) tick();
    chk("s4_mem_401", mem_a[16'h0401], 8'h22);
    chk("s4_mem_500", mem_a[16'h0500], 8'h77);

    // Reset in the middle of a DMA burst on A
    repeat (6) tick();
    tick();
    dma_req_a = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
    #2;
    chk("s5_req_gnt", dma_gnt_a, 0);
    tick();
    #2;
    chk("s5_gnt", dma_gnt_a, 1);
    tick();
    resetn = 1'b0; dma_we = 1'b1; dma_addr = 16'h0300; dma_wr_data = 8'hEE;
    #2;
    chk("s5_we_dropped", mem_we_a, 0);
    chk("s5_rdy", cpu_rdy_a, 1);
    chk("s5_gnt_off", dma_gnt_a, 0);
    chk("s5_rd_valid", dma_rd_valid_a, 0);
    chk("s5_mem_addr", mem_addr_a, 16'h1234);
    tick();
    resetn = 1'b1; dma_req_a = 1'b0; dma_we = 1'b0;
    #2;
    chk("s5_mem_300", mem_a[16'h0300], 8'h3C);

`ifdef ARB_STATS_EN
    // Long DMA hold on D drives the stall counter into saturation
    tick();
    dma_req_d = 1'b1;
    repeat (65700) tick();
    #2;
    chk("s6_saturate", stall_d, 16'hFFFF);
    tick();
    #2;
    chk("s6_saturate_hold", stall_d, 16'hFFFF);
    dma_req_d = 1'b0;
`endif

    repeat (2) tick();
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
